// File: rtl/alu_ex_stage.sv
// Execute-stage ALU for the RV32I pipeline: one shared 33-bit adder, one shifter,
// registered result/flags/rd into EX/MEM with stall (hold) and flush (bubble).

module alu_shifter (
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  input  logic [1:0]  shtype,
  output logic [31:0] y
);

  always_comb begin
    case (shtype)
      2'b01:   y = a << shamt;
      2'b10:   y = $unsigned($signed(a) >>> shamt);
      default: y = a >> shamt;
    endcase
  end

endmodule

module alu_ex_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              reg_write_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              zf,
  output logic              cf,
  output logic              vf,
  output logic              sf,
  output logic [RD_W-1:0]   rd_out,
  output logic              reg_write_out
);

  localparam logic [3:0] SEL_ADD   = 4'b0000;
  localparam logic [3:0] SEL_SUB   = 4'b0001;
  localparam logic [3:0] SEL_AND   = 4'b0010;
  localparam logic [3:0] SEL_OR    = 4'b0011;
  localparam logic [3:0] SEL_XOR   = 4'b0100;
  localparam logic [3:0] SEL_SLL   = 4'b0101;
  localparam logic [3:0] SEL_SRL   = 4'b0110;
  localparam logic [3:0] SEL_SRA   = 4'b0111;
  localparam logic [3:0] SEL_SLT   = 4'b1000;
  localparam logic [3:0] SEL_SLTU  = 4'b1001;
  localparam logic [3:0] SEL_PASSB = 4'b1010;

  logic              sub_op;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;
  logic              carry;
  logic              ovf;
  logic              lt_signed;
  logic [1:0]        shtype;
  logic [DATA_W-1:0] sh_y;
  logic [DATA_W-1:0] res_c;
  logic              cf_c;
  logic              vf_c;

  // SLT/SLTU reuse the subtract path; compare outcome comes from its flags.
  assign sub_op = (alu_sel == SEL_SUB) || (alu_sel == SEL_SLT) || (alu_sel == SEL_SLTU);
  assign b_eff  = sub_op ? ~op_b : op_b;
  assign sum    = {1'b0, op_a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub_op};
  assign carry  = sum[DATA_W];
  assign ovf    = (op_a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != op_a[DATA_W-1]);
  assign lt_signed = sum[DATA_W-1] ^ ovf;

  always_comb begin
    shtype = 2'b00;
    case (alu_sel)
      SEL_SLL: shtype = 2'b01;
      SEL_SRA: shtype = 2'b10;
      default: shtype = 2'b00;
    endcase
  end

  alu_shifter u_shifter (
    .a      (op_a),
    .shamt  (op_b[4:0]),
    .shtype (shtype),
    .y      (sh_y)
  );

  always_comb begin
    res_c = '0;
    cf_c  = 1'b0;
    vf_c  = 1'b0;
    case (alu_sel)
      SEL_ADD, SEL_SUB: begin
        res_c = sum[DATA_W-1:0];
        cf_c  = carry;
        vf_c  = ovf;
      end
      SEL_AND:   res_c = op_a & op_b;
      SEL_OR:    res_c = op_a | op_b;
      SEL_XOR:   res_c = op_a ^ op_b;
      SEL_SLL, SEL_SRL, SEL_SRA: res_c = sh_y;
      SEL_SLT:   res_c = {{(DATA_W-1){1'b0}}, lt_signed};
      SEL_SLTU:  res_c = {{(DATA_W-1){1'b0}}, ~carry};
      SEL_PASSB: res_c = op_b;
      default:   res_c = '0;
    endcase
  end

  // Priority at each edge: reset, then flush, then stall (hold), then load.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      out_valid     <= 1'b0;
      reg_write_out <= 1'b0;
      result        <= '0;
      zf            <= 1'b0;
      cf            <= 1'b0;
      vf            <= 1'b0;
      sf            <= 1'b0;
      rd_out        <= '0;
    end else if (!stall) begin
      out_valid     <= in_valid;
      reg_write_out <= reg_write_in & in_valid;
      result        <= res_c;
      zf            <= (res_c == '0);
      cf            <= cf_c;
      vf            <= vf_c;
      sf            <= res_c[DATA_W-1];
      rd_out        <= rd_in;
    end
  end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Self-checking bench for alu_ex_stage: directed boundary cases with literal
// expectations, then randomized traffic checked every cycle against a model.

module tb_alu_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [3:0]  alu_sel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        out_valid;
  logic [31:0] result;
  logic        zf, cf, vf, sf;
  logic [4:0]  rd_out;
  logic        reg_write_out;

  int vectors = 0;
  int miscompares = 0;

  logic        started = 1'b0;
  logic        m_valid, m_rw;
  logic [4:0]  m_rd;
  logic [35:0] m_alu;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  alu_ex_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .stall         (stall),
    .flush         (flush),
    .alu_sel       (alu_sel),
    .op_a          (op_a),
    .op_b          (op_b),
    .rd_in         (rd_in),
    .reg_write_in  (reg_write_in),
    .out_valid     (out_valid),
    .result        (result),
    .zf            (zf),
    .cf            (cf),
    .vf            (vf),
    .sf            (sf),
    .rd_out        (rd_out),
    .reg_write_out (reg_write_out)
  );

  always #5 clk = ~clk;

  // Returns {zf, cf, vf, sf, result} from plain integer arithmetic.
  function automatic logic [35:0] model_alu(input logic [3:0] sel, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    logic c, v;
    longint sa, sb, sr;
    longint unsigned ua, ub;
    r = 32'h0; c = 1'b0; v = 1'b0;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a); ub = longint'(b);
    case (sel)
      4'd0: begin
        r = a + b; c = ((ua + ub) > 64'hFFFF_FFFF);
        sr = sa + sb; v = (sr > MAXS) || (sr < MINS);
      end
      4'd1: begin
        r = a - b; c = (a >= b);
        sr = sa - sb; v = (sr > MAXS) || (sr < MINS);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = $unsigned($signed(a) >>> b[4:0]);
      4'd8: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
      4'd10: r = b;
      default: r = 32'h0;
    endcase
    return {(r == 32'h0), c, v, r[31], r};
  endfunction

  always @(posedge clk) begin
    started <= 1'b1;
    if (!rst || flush) begin
      m_valid <= 1'b0; m_rw <= 1'b0; m_rd <= 5'd0; m_alu <= 36'h0;
    end else if (!stall) begin
      m_valid <= in_valid;
      m_rw    <= in_valid & reg_write_in;
      m_rd    <= rd_in;
      m_alu   <= model_alu(alu_sel, op_a, op_b);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      vectors++;
      if ({out_valid, reg_write_out, rd_out, zf, cf, vf, sf, result} !==
          {m_valid, m_rw, m_rd, m_alu}) begin
        miscompares++;
        $display("[TB] FAIL model t=%0t got v=%b rw=%b rd=%0d zcvs=%b%b%b%b res=%h want v=%b rw=%b rd=%0d zcvs=%b res=%h",
                 $time, out_valid, reg_write_out, rd_out, zf, cf, vf, sf, result,
                 m_valid, m_rw, m_rd, m_alu[35:32], m_alu[31:0]);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic v, input logic st, input logic fl,
                               input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                               input logic rw);
    rst = r; in_valid = v; stall = st; flush = fl;
    alu_sel = sel; op_a = a; op_b = b; reg_write_in = rw;
    rd_in = 5'($urandom_range(0, 31));
    @(negedge clk);
  endtask

  // Literal expectation: {valid, rw, zf, cf, vf, sf, result}.
  task automatic checkOutput(input string name, input logic ev, input logic erw,
                             input logic [3:0] ezcvs, input logic [31:0] eres);
    vectors++;
    if ({out_valid, reg_write_out, zf, cf, vf, sf, result} !== {ev, erw, ezcvs, eres}) begin
      miscompares++;
      $display("[TB] FAIL %s got v=%b rw=%b zcvs=%b%b%b%b res=%h want v=%b rw=%b zcvs=%b res=%h",
               name, out_valid, reg_write_out, zf, cf, vf, sf, result, ev, erw, ezcvs, eres);
    end
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd5, 32'd7, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd5, 32'd7, 1'b1);
    checkOutput("reset", 1'b0, 1'b0, 4'b0000, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'd5, 32'd7, 1'b1);
    checkOutput("add_after_reset", 1'b1, 1'b1, 4'b0000, 32'd12);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h7FFF_FFFF, 32'h1, 1'b1);
    checkOutput("add_ovf", 1'b1, 1'b1, 4'b0011, 32'h8000_0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 32'd3, 32'd3, 1'b1);
    checkOutput("sub_zero", 1'b1, 1'b1, 4'b1100, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 32'd0, 32'd1, 1'b1);
    checkOutput("sub_borrow", 1'b1, 1'b1, 4'b0001, 32'hFFFF_FFFF);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 32'h8000_0000, 32'hFFFF_FFE4, 1'b1);
    checkOutput("sra4", 1'b1, 1'b1, 4'b0001, 32'hF800_0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 32'h8000_0000, 32'hFFFF_FFE4, 1'b1);
    checkOutput("srl4", 1'b1, 1'b1, 4'b0000, 32'h0800_0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 32'h1, 32'd31, 1'b1);
    checkOutput("sll31", 1'b1, 1'b1, 4'b0001, 32'h8000_0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 32'h1234_5678, 32'hFFFF_FFE0, 1'b1);
    checkOutput("shamt0", 1'b1, 1'b1, 4'b0000, 32'h1234_5678);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 32'h8000_0001, 32'd31, 1'b1);
    checkOutput("sra31", 1'b1, 1'b1, 4'b0001, 32'hFFFF_FFFF);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd8, 32'hFFFF_FFFF, 32'h1, 1'b1);
    checkOutput("slt_neg", 1'b1, 1'b1, 4'b0000, 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 32'hFFFF_FFFF, 32'h1, 1'b1);
    checkOutput("sltu_big", 1'b1, 1'b1, 4'b1000, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd8, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    checkOutput("slt_ovf", 1'b1, 1'b1, 4'b0000, 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd12, 32'h1234_5678, 32'h1, 1'b1);
    checkOutput("unused_sel", 1'b1, 1'b1, 4'b1000, 32'h0);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'd1, 32'd1, 1'b1);
    checkOutput("pre_stall", 1'b1, 1'b1, 4'b0000, 32'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 4'($urandom_range(0, 10)),
                    $urandom, $urandom, 1'b1);
      checkOutput("stall_hold", 1'b1, 1'b1, 4'b0000, 32'd2);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 32'd9, 32'd9, 1'b1);
    checkOutput("flush_stall", 1'b0, 1'b0, 4'b0000, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd4, 32'd4, 1'b1);
    checkOutput("bubble", 1'b0, 1'b0, 4'b0000, 32'd8);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                    4'($urandom_range(0, 15)), pick_op(), pick_op(),
                    1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
- Execute-stage ALU for the pipelined RV32I core.
- Sits between the ID/EX pipeline register and EX/MEM. Computes arithmetic, logic, compare and shift results; all shifts go through one instance of the core's combinational shifter.
- Registers the result, branch flags and destination bookkeeping into the EX/MEM boundary.
- Supports pipeline stall (hold) and flush (bubble insertion).

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported.
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  ID/EX slot holds a real instruction.
- stall  input  1  hazard unit requests EX/MEM hold.
- flush  input  1  squash: insert a bubble into EX/MEM.
- alu_sel  input  4  operation select; encodings in Behaviour.
- op_a  input  32  operand A (rs1 or PC, already forwarded).
- op_b  input  32  operand B (rs2 or immediate, already forwarded).
- rd_in  input  5  destination register index.
- reg_write_in  input  1  instruction writes rd.
- out_valid  output  1  EX/MEM slot holds a real instruction.
- result  output  32  registered ALU result.
- zf, cf, vf, sf  output  1 each  registered zero, carry, overflow and sign flags.
- rd_out  output  5  registered rd.
- reg_write_out  output  1  registered write enable, gated by validity.

Behaviour:
- Reset (rst==0 at a clock edge): out_valid, result, zf, cf, vf, sf, rd_out and reg_write_out all become 0. Reset overrides stall and flush, and aborts any held or in-flight operation.
- Update priority at each edge: reset > flush > stall > load.
- Flush: out_valid=0, reg_write_out=0, result=0, all flags=0, rd_out=0. Flush wins over a simultaneous stall.
- Stall (no flush): every output register holds its value. Inputs presented during a stall are ignored; the upstream stage holds them.
- Load: out_valid<=in_valid; reg_write_out<=reg_write_in & in_valid. result, flags and rd_out load the computed values regardless of in_valid.
- Latency: inputs sampled at edge N appear on the outputs after edge N. Throughput is one operation per cycle with no internal back-pressure.
- alu_sel encodings:
  - 0000 ADD: a+b
  - 0001 SUB: a-b
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SLL
  - 0110 SRL
  - 0111 SRA
  - 1000 SLT: signed less-than, result 1 or 0
  - 1001 SLTU: unsigned less-than, result 1 or 0
  - 1010 PASSB: result=b (LUI)
  - 1011-1111: result=0, flags computed normally from that result.
- Shifts: the shifter instance takes a=op_a and shamt=op_b[4:0]; op_b[31:5] is ignored. Shifter type: 2'b00 SRL, 2'b01 SLL, 2'b10 SRA; 2'b11 is never driven. The type input is driven from alu_sel for shift ops and held at 2'b00 otherwise.
- Arithmetic: a single 33-bit adder computes a + (SUB ? ~b : b) + SUB. SLT and SLTU reuse the SUB path.
  - SLT result = sf ^ vf of the subtraction.
  - SLTU result = ~carry of the subtraction.
- Flags (registered with result):
  - zf = (result==0).
  - sf = result[31].
  - cf = adder carry-out for ADD and SUB, else 0. For SUB, cf=1 means a>=b unsigned.
  - vf = signed overflow for ADD and SUB, else 0.
- Boundary values:
  - Shift by 0 passes a unchanged.
  - SRA by 31 of a negative value gives 0xFFFFFFFF.
  - ADD 0x7FFFFFFF+1 sets vf=1.
  - SUB 0-1 gives 0xFFFFFFFF with cf=0.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 and ADD 5+7 -> all outputs 0. Release rst -> after the next edge result=12, out_valid=1, zf=0.
- Arithmetic and flags:
  - ADD 0x7FFFFFFF+0x00000001 -> result=0x80000000, vf=1, sf=1, cf=0.
  - SUB 3-3 -> result=0, zf=1, cf=1.
  - SUB 0-1 -> 0xFFFFFFFF, cf=0, sf=1.
- Shifts via the shifter:
  - SRA a=0x80000000, b=0xFFFFFFE4 (shamt=4) -> 0xF8000000.
  - SRL same operands -> 0x08000000.
  - SLL a=1, b=31 -> 0x80000000.
  - shamt 0 -> a unchanged.
- Compares:
  - SLT a=0xFFFFFFFF, b=1 -> 1.
  - SLTU same operands -> 0.
  - SLT a=0x80000000, b=0x7FFFFFFF -> 1 (overflow case).
- Stall and flush:
  - Load ADD 1+1 (result 2), then assert stall for 3 cycles while changing inputs -> result stays 2, out_valid stays 1.
  - Assert stall and flush together -> out_valid=0, reg_write_out=0, result=0.
- Bubble gating: in_valid=0, reg_write_in=1, ADD 4+4 -> out_valid=0, reg_write_out=0, result=8.
